aes_cipher_collector: RTL and testbench

Downstream stage of the AES engine output interface. It consumes the engine's byte-serial ciphertext stream (`dout`/`data_ok`), reassembles each 16-byte block into a 128-bit word, and buffers completed blocks in a small FIFO. Blocks are presented to the host side through a valid/ready handshake. Overflow and a running block count are exposed for status.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_block_fifo.sv | 77 +++++++
 rtl/aes_cipher_collector.sv | 94 +++++++++
 tb/tb_aes_cipher_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the output-side blocks.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_BYTE_W          = 8;
  localparam int AES_BYTES_PER_BLOCK = 16;
  localparam int AES_BCNT_W          = $clog2(AES_BYTES_PER_BLOCK);

  // Byte counter value at which the incoming byte completes a block.
  localparam logic [AES_BCNT_W-1:0] AES_LAST_BYTE = AES_BCNT_W'(AES_BYTES_PER_BLOCK - 1);

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

endpackage

// File: rtl/aes_block_fifo.sv
// Small block FIFO with a registered head word. A push is accepted when
// not full, or when full and a pop happens in the same cycle.
module aes_block_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          pop, push_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop     = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop);

  // Next-state for pointers, occupancy and the registered head word.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    head_d  = head_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Head tracks the entry at the next read pointer; when that slot is being
    // written this cycle the incoming word is forwarded. When the FIFO drains
    // the head keeps the last word that was read.
    if (level_d != '0) begin
      if (push_ok && (wptr_q == rptr_d)) head_d = push_data_i;
      else                               head_d = mem_q[rptr_d];
    end
  end

  // Control state, async reset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = head_q;
  assign level_o = level_q;

endmodule

// File: rtl/aes_cipher_collector.sv
// Reassembles the engine's byte-serial ciphertext into 128-bit blocks and
// queues them for the host behind a valid/ready handshake.
module aes_cipher_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [AES_BYTE_W-1:0]  din,
  input  logic                   din_ok,
  input  logic                   clr,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       blk_count
);

  logic [AES_BLOCK_W-AES_BYTE_W-1:0] sr_q, sr_d;
  logic [AES_BCNT_W-1:0]             bcnt_q, bcnt_d;
  logic                              ovf_q, ovf_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic       byte_acc, blk_done, pop, push_acc;
  logic       fifo_full, fifo_empty;
  aes_block_t blk_word;

  // clr wins over a same-cycle byte strobe; that byte is discarded.
  assign byte_acc = din_ok && !clr;
  assign blk_done = byte_acc && (bcnt_q == AES_LAST_BYTE);
  assign blk_word = {sr_q, din};
  assign pop      = out_valid && out_ready;
  assign push_acc = blk_done && (!fifo_full || pop);

  // Byte assembly, block counter and sticky overflow next-state.
  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (clr) begin
      bcnt_d = '0;
      ovf_d  = 1'b0;
    end else if (byte_acc) begin
      if (blk_done) begin
        // A rejected block still resets bcnt so the next byte starts fresh.
        bcnt_d = '0;
        if (push_acc) cnt_d = cnt_q + CNT_W'(1);
        else          ovf_d = 1'b1;
      end else begin
        sr_d   = {sr_q[AES_BLOCK_W-2*AES_BYTE_W-1:0], din};
        bcnt_d = bcnt_q + AES_BCNT_W'(1);
      end
    end
  end

  // Assembler and status registers, async reset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      sr_q   <= '0;
      bcnt_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  aes_block_fifo #(
    .W     (AES_BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_        (rst_),
    .push_i      (blk_done),
    .push_data_i (blk_word),
    .pop_i       (pop),
    .head_o      (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = ovf_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Self-checking bench: block table plus hand sequences, with a queue-based
// scoreboard checked against the DUT every cycle.
module tb_aes_cipher_collector;
  import aes_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] BLK_D = 128'h5a5aa5a5c3c33c3c0f0ff0f011223344;

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic [7:0]   din = '0;
  logic         din_ok = 1'b0;
  logic         clr = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_valid;
  logic [$clog2(DEPTH):0] level;
  logic         overflow;
  logic [CNT_W-1:0] blk_count;

  int checks = 0;
  int failures = 0;

  // Scoreboard / reference model state
  logic [127:0] q[$];
  int           mbcnt;
  logic [127:0] msr;
  logic         movf;
  int           mcnt;
  int           pops;
  int           max_level;
  logic         rdy_base = 1'b0;

  typedef struct {
    logic [127:0] blk;
    int           gap;
    logic [127:0] exp_head;
    int           exp_level;
    int           exp_cnt;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[3];

  aes_cipher_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .din       (din),
    .din_ok    (din_ok),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mbcnt = 0;
    msr   = '0;
    movf  = 1'b0;
    mcnt  = 0;
  endtask

  // One clock: compare DUT against the model at the falling edge, advance the
  // model with the inputs currently driven, then step past the rising edge.
  task automatic cycle();
    logic         p_pop, p_push, p_acc;
    logic [127:0] word;
    @(negedge clk);
    if (!rst_) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", overflow, movf);
      chk("blk_count", blk_count, mcnt[15:0]);
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      if (int'(level) > max_level) max_level = int'(level);
      p_pop  = (q.size() != 0) && out_ready;
      p_push = din_ok && !clr && (mbcnt == 15);
      p_acc  = p_push && ((q.size() < DEPTH) || p_pop);
      if (p_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (din_ok && !clr) begin
        word = {msr[119:0], din};
        if (mbcnt == 15) begin
          if (p_acc) begin
            q.push_back(word);
            mcnt++;
          end else begin
            movf = 1'b1;
          end
          mbcnt = 0;
        end else begin
          msr = word;
          mbcnt++;
        end
      end
      if (clr) begin
        mbcnt = 0;
        movf  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] b, input int gap, input logic rdy_last);
    for (int i = 0; i < 16; i++) begin
      din       = b[127-8*i -: 8];
      din_ok    = 1'b1;
      out_ready = (i == 15 && rdy_last) ? 1'b1 : rdy_base;
      cycle();
      din_ok    = 1'b0;
      out_ready = rdy_base;
      if (i != 15) repeat (gap) cycle();
    end
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    din_ok = 1'b0;
    clr = 1'b0;
    #1;
    model_reset();
    repeat (2) cycle();
    rst_ = 1'b0;
  endtask

  initial begin
    tbl[0] = '{blk: BLK_A, gap: 0, exp_head: BLK_A, exp_level: 1, exp_cnt: 1, exp_ovf: 1'b0};
    tbl[1] = '{blk: BLK_A, gap: 3, exp_head: BLK_A, exp_level: 2, exp_cnt: 2, exp_ovf: 1'b0};
    tbl[2] = '{blk: BLK_C, gap: 0, exp_head: BLK_A, exp_level: 2, exp_cnt: 2, exp_ovf: 1'b1};
    pops = 0;
    max_level = 0;
    model_reset();

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_blk_count", blk_count, 0);
    do_reset();

    // Single block, gapped strobe, overflow (out_ready held low)
    for (int v = 0; v < 3; v++) begin
      send_block(tbl[v].blk, tbl[v].gap, 1'b0);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_data", out_data, tbl[v].exp_head);
      chk("tbl_level", level, tbl[v].exp_level);
      chk("tbl_blk_count", blk_count, tbl[v].exp_cnt);
      chk("tbl_overflow", overflow, tbl[v].exp_ovf);
    end

    // clr drops overflow but keeps the queued blocks
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_level", level, 2);
    cycle();

    // Full FIFO with a pop in the same cycle as the 16th byte
    send_block(BLK_B, 0, 1'b1);
    chk("fullpop_level", level, 2);
    chk("fullpop_overflow", overflow, 0);
    chk("fullpop_blk_count", blk_count, 3);
    chk("fullpop_head", out_data, BLK_A);
    rdy_base = 1'b1;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_pops", pops, 3);
    chk("drain_level", level, 0);
    rdy_base = 1'b0;
    out_ready = 1'b0;

    // Reset in the middle of a block with a block already queued
    send_block(BLK_C, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      din = BLK_D[127-8*i -: 8];
      din_ok = 1'b1;
      cycle();
    end
    din_ok = 1'b0;
    rst_ = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_level", level, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_blk_count", blk_count, 0);
    do_reset();
    send_block(BLK_D, 0, 1'b0);
    chk("postrst_out_data", out_data, BLK_D);
    chk("postrst_level", level, 1);
    chk("postrst_blk_count", blk_count, 1);

    // Continuous stream with the consumer always ready
    do_reset();
    pops = 0;
    max_level = 0;
    rdy_base = 1'b1;
    out_ready = 1'b1;
    send_block(BLK_A, 0, 1'b0);
    send_block(BLK_B, 0, 1'b0);
    send_block(BLK_C, 0, 1'b0);
    send_block(BLK_D, 0, 1'b0);
    repeat (3) cycle();
    chk("stream_pops", pops, 4);
    chk("stream_max_level_le1", max_level <= 1, 1);
    chk("stream_blk_count", blk_count, 4);
    chk("stream_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
